// File: rtl/mips_enc_pkg.sv
// mips_enc_pkg: opcodes, request kinds and loader states shared by the loader
package mips_enc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] KIND_RTYPE = 3'd0;
    localparam logic [2:0] KIND_LW    = 3'd1;
    localparam logic [2:0] KIND_SW    = 3'd2;
    localparam logic [2:0] KIND_BEQ   = 3'd3;
    localparam logic [2:0] KIND_ADDI  = 3'd4;
    localparam logic [2:0] KIND_J     = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_e;

endpackage

// File: rtl/instr_field_packer.sv
// instr_field_packer: combinational kind+fields to 32-bit MIPS word encoder
module instr_field_packer
    import mips_enc_pkg::*;
(
    input  logic [2:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    // kinds 6 and 7 have no encoding and are flagged illegal with a zero word
    always_comb begin
        word_o    = 32'h0;
        illegal_o = 1'b0;
        case (kind_i)
            KIND_RTYPE: word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b00000, funct_i};
            KIND_LW:    word_o = {OP_LW, rs_i, rt_i, imm_i};
            KIND_SW:    word_o = {OP_SW, rs_i, rt_i, imm_i};
            KIND_BEQ:   word_o = {OP_BEQ, rs_i, rt_i, imm_i};
            KIND_ADDI:  word_o = {OP_ADDI, rs_i, rt_i, imm_i};
            KIND_J:     word_o = {OP_J, target_i};
            default:    illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_instr_loader.sv
// mips_instr_loader: encodes field-level requests and loads them into imem (optional LOADER_CHECKSUM_EN)
module mips_instr_loader
    import mips_enc_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [5:0]        req_funct,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic [ADDR_W:0]   count,
`ifdef LOADER_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic              err_illegal,
    output logic              err_full,
    output logic              done
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [31:0]         word_q, word_d;
    logic                ill_q, ill_d;
    logic                full_q, full_d;
    logic                pend_q, pend_d;
    logic [31:0]         pk_word;
    logic                pk_illegal;
    logic                at_full;
    logic                accept;

    instr_field_packer u_packer (
        .kind_i    (req_kind),
        .rs_i      (req_rs),
        .rt_i      (req_rt),
        .rd_i      (req_rd),
        .funct_i   (req_funct),
        .imm_i     (req_imm),
        .target_i  (req_target),
        .word_o    (pk_word),
        .illegal_o (pk_illegal)
    );

    assign at_full    = count_q == (ADDR_W+1)'(DEPTH);
    assign accept     = state_q == S_LOAD && req_valid && !pk_illegal && !at_full;
    assign req_ready  = state_q == S_LOAD;
    assign core_hold  = state_q != S_IDLE;
    assign imem_we    = state_q == S_WRITE;
    assign done       = state_q == S_DONE;
    assign imem_addr  = addr_q;
    assign imem_wdata = word_q;
    assign count      = count_q;
    assign err_illegal = ill_q;
    assign err_full   = full_q;

    // session sequencing and per-beat bookkeeping
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        word_d  = word_q;
        ill_d   = ill_q;
        full_d  = full_q;
        pend_d  = pend_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    count_d = '0;
                    ill_d   = 1'b0;
                    full_d  = 1'b0;
                    pend_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (req_valid && pk_illegal) ill_d = 1'b1;
                if (req_valid && at_full) full_d = 1'b1;
                if (accept) begin
                    word_d  = pk_word;
                    pend_d  = finish;
                    state_d = S_WRITE;
                end else if (finish) begin
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                count_d = at_full ? count_q : count_q + (ADDR_W+1)'(1);
                state_d = (pend_q || finish) ? S_DONE : S_LOAD;
                pend_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            word_q  <= '0;
            ill_q   <= 1'b0;
            full_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            word_q  <= word_d;
            ill_q   <= ill_d;
            full_q  <= full_d;
            pend_q  <= pend_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] cks_q, cks_d;

    assign checksum = cks_q;
    assign cks_d    = (state_q == S_IDLE && start) ? 32'h0 :
                      (state_q == S_WRITE) ? cks_q ^ word_q : cks_q;

    // running XOR of every word written this session
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cks_q <= 32'h0;
        else cks_q <= cks_d;
    end
`endif

endmodule

// File: tb/tb_mips_instr_loader.sv
// tb_mips_instr_loader: directed self-checking bench for mips_instr_loader
module tb_mips_instr_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        finish = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_kind = 3'd0;
    logic [4:0]  req_rs = 5'd0;
    logic [4:0]  req_rt = 5'd0;
    logic [4:0]  req_rd = 5'd0;
    logic [5:0]  req_funct = 6'd0;
    logic [15:0] req_imm = 16'd0;
    logic [25:0] req_target = 26'd0;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic [6:0]  count;
    logic        err_illegal;
    logic        err_full;
    logic        done;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_instr_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .finish     (finish),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .req_rd     (req_rd),
        .req_funct  (req_funct),
        .req_imm    (req_imm),
        .req_target (req_target),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .count      (count),
`ifdef LOADER_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .err_illegal(err_illegal),
        .err_full   (err_full),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                         input logic [25:0] tg);
        req_valid  = 1'b1;
        req_kind   = k;
        req_rs     = rs;
        req_rt     = rt;
        req_rd     = rd;
        req_funct  = fn;
        req_imm    = imm;
        req_target = tg;
    endtask

    // one beat from LOAD: drive at a negedge, check the write one negedge later
    task automatic send(input string tag, input logic [2:0] k, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn,
                        input logic [15:0] imm, input logic [25:0] tg,
                        input logic [5:0] exp_addr, input logic [31:0] exp_word);
        @(negedge clk);
        drive(k, rs, rt, rd, fn, imm, tg);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_we"}, 32'(imem_we), 32'd1);
        check({tag, "_addr"}, 32'(imem_addr), 32'(exp_addr));
        check({tag, "_data"}, imem_wdata, exp_word);
    endtask

    task automatic begin_session();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic end_session(input string tag, input logic [6:0] exp_count);
        @(negedge clk);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_hold_done"}, 32'(core_hold), 32'd1);
        @(negedge clk);
        check({tag, "_done_off"}, 32'(done), 32'd0);
        check({tag, "_hold_idle"}, 32'(core_hold), 32'd0);
        check({tag, "_count"}, 32'(count), 32'(exp_count));
    endtask

    initial begin
        #12;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_hold", 32'(core_hold), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_errs", {30'd0, err_illegal, err_full}, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        begin_session();
        check("s1_ready", 32'(req_ready), 32'd1);
        check("s1_hold", 32'(core_hold), 32'd1);
        send("s1_r", 3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 6'd0, 32'h00221820);
        check("s1_ready_wr", 32'(req_ready), 32'd0);
        send("s1_lw", 3'd1, 5'd0, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0, 6'd1, 32'h8C080004);
`ifdef LOADER_CHECKSUM_EN
        @(negedge clk);
        check("s1_cks", checksum, 32'h8C2A1824);
`endif
        send("s1_beq", 3'd3, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0003, 26'h0, 6'd2, 32'h10220003);
        end_session("s1", 7'd3);

        begin_session();
        check("s2_count_clr", 32'(count), 32'd0);
        send("s2_addi", 3'd4, 5'd0, 5'd9, 5'd0, 6'h0, 16'hFFFF, 26'h0, 6'd0, 32'h2009FFFF);
        send("s2_j", 3'd5, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 6'd1, 32'h08000010);
        @(negedge clk);
        drive(3'd7, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1);
        @(negedge clk);
        req_valid = 1'b0;
        check("s2_ill_we", 32'(imem_we), 32'd0);
        check("s2_ill_err", 32'(err_illegal), 32'd1);
        check("s2_ill_addr", 32'(imem_addr), 32'd2);
        check("s2_ill_count", 32'(count), 32'd2);
        check("s2_ill_ready", 32'(req_ready), 32'd1);
        end_session("s2", 7'd2);

        begin_session();
        check("s3_ill_clr", 32'(err_illegal), 32'd0);
        for (int i = 0; i < 64; i++)
            send("s3_fill", 3'd4, 5'd0, 5'd1, 5'd0, 6'h0, 16'(i), 26'h0, 6'(i),
                 {16'h2001, 16'(i)});
        @(negedge clk);
        check("s3_count64", 32'(count), 32'd64);
        check("s3_addr_wrap", 32'(imem_addr), 32'd0);
        drive(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0);
        @(negedge clk);
        req_valid = 1'b0;
        check("s3_full_we", 32'(imem_we), 32'd0);
        check("s3_full_err", 32'(err_full), 32'd1);
        check("s3_full_count", 32'(count), 32'd64);
        end_session("s3", 7'd64);

        begin_session();
        check("s4_full_clr", 32'(err_full), 32'd0);
        @(negedge clk);
        drive(3'd2, 5'd4, 5'd5, 5'd0, 6'h0, 16'h0010, 26'h0);
        finish = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        finish = 1'b0;
        start = 1'b1;
        check("s4_we", 32'(imem_we), 32'd1);
        check("s4_data", imem_wdata, 32'hAC850010);
        @(negedge clk);
        start = 1'b0;
        check("s4_done", 32'(done), 32'd1);
        @(negedge clk);
        check("s4_idle_hold", 32'(core_hold), 32'd0);
        check("s4_idle_ready", 32'(req_ready), 32'd0);
        check("s4_count", 32'(count), 32'd1);

        begin_session();
        send("s5_a", 3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 6'd0, 32'h00221820);
        @(negedge clk);
        drive(3'd1, 5'd0, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0);
        @(negedge clk);
        req_valid = 1'b0;
        check("s5_we_pre", 32'(imem_we), 32'd1);
        rst = 1'b1;
        #1;
        check("s5_rst_we", 32'(imem_we), 32'd0);
        check("s5_rst_hold", 32'(core_hold), 32'd0);
        check("s5_rst_count", 32'(count), 32'd0);
        check("s5_rst_addr", 32'(imem_addr), 32'd0);
        check("s5_rst_wdata", imem_wdata, 32'd0);
        check("s5_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin_session();
        send("s5_after", 3'd1, 5'd0, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0, 6'd0, 32'h8C080004);
        end_session("s5", 7'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
